dsp_zender: RTL and testbench

- Behavioural and synthesizable DSP-side responder for the crying-volume serial link.
- huilVolume raises DSPctrl to request a sample. This block answers on DSPingang with a framed serial word carrying the current crying volume.
- Used as the DSP stand-in on the FPGA test board and as the bench driver for huilVolume.
- Volume samples arrive on a parallel port, from an ADC front end or a test pattern source.

---
 rtl/dsp_pkg.sv | 20 ++
 rtl/dsp_flank.sv | 27 ++
 rtl/dsp_zender.sv | 137 +++++++++++++
 tb/tb_dsp_zender.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared types and default constants for the crying-volume DSP link blocks.
package dsp_pkg;

   localparam int unsigned DSP_WIDTH       = 8;
   localparam int unsigned DSP_BIT_CYCLES  = 16;
   localparam int unsigned DSP_TURN_CYCLES = 4;

   typedef enum logic [2:0] {
      IDLE,
      TURN,
      START,
      DATA,
      STOP
   } state_t;

   function automatic int unsigned dsp_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dsp_flank.sv
// Two-flop synchronizer followed by a rising-edge detector on the synchronized level.
module dsp_flank (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise_c
);

   logic s1;
   logic s2;
   logic prev;

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
      end else begin
         s1   <= din;
         s2   <= s1;
         prev <= s2;
      end
   end

   assign rise_c = s2 & ~prev;

endmodule

// File: rtl/dsp_zender.sv
// DSP-side responder: on a DSPctrl request, sends a framed MSB-first serial word on DSPingang.
module dsp_zender
   import dsp_pkg::*;
#(
   parameter int unsigned WIDTH       = DSP_WIDTH,
   parameter int unsigned BIT_CYCLES  = DSP_BIT_CYCLES,
   parameter int unsigned TURN_CYCLES = DSP_TURN_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             DSPctrl,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             sample_valid,
   output logic             DSPingang,
   output logic             busy,
   output logic             sample_taken,
   output logic             overrun
);

   localparam int unsigned CW = $clog2(dsp_max(dsp_max(BIT_CYCLES, TURN_CYCLES), 2));
   localparam int unsigned BW = $clog2(dsp_max(WIDTH, 2));

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [BW-1:0]    bitcnt, bitcnt_n;
   logic [WIDTH-1:0] shift, shift_n;
   logic [WIDTH-1:0] shadow;
   logic             req_c;
   logic             dsp_n, busy_n, taken_n, overrun_n;

   dsp_flank u_flank (
      .clk    (clk),
      .reset  (reset),
      .din    (DSPctrl),
      .rise_c (req_c)
   );

   // Shadow keeps the latest sample so a request without a fresh strobe resends it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         shadow <= '0;
      end else if (sample_valid) begin
         shadow <= sample_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= '0;
         bitcnt       <= '0;
         shift        <= '0;
         DSPingang    <= 1'b0;
         busy         <= 1'b0;
         sample_taken <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         bitcnt       <= bitcnt_n;
         shift        <= shift_n;
         DSPingang    <= dsp_n;
         busy         <= busy_n;
         sample_taken <= taken_n;
         overrun      <= overrun_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bitcnt_n  = bitcnt;
      shift_n   = shift;
      taken_n   = 1'b0;
      overrun_n = overrun | (req_c && (state != IDLE));

      case (state)
         IDLE: begin
            if (req_c) begin
               state_n  = TURN;
               cnt_n    = '0;
               bitcnt_n = '0;
               shift_n  = sample_valid ? sample_in : shadow;
               taken_n  = 1'b1;
            end
         end
         TURN: begin
            if (cnt == CW'(TURN_CYCLES - 1)) begin
               state_n = START;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         START: begin
            if (cnt == CW'(BIT_CYCLES - 1)) begin
               state_n  = DATA;
               cnt_n    = '0;
               bitcnt_n = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DATA: begin
            if (cnt == CW'(BIT_CYCLES - 1)) begin
               cnt_n   = '0;
               shift_n = shift << 1;
               if (bitcnt == BW'(WIDTH - 1)) begin
                  state_n  = STOP;
                  bitcnt_n = '0;
               end else begin
                  bitcnt_n = bitcnt + BW'(1);
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         STOP: begin
            if (cnt == CW'(BIT_CYCLES - 1)) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase

      // Output registers follow the state being entered, so the line changes with the state.
      dsp_n  = (state_n == START) || ((state_n == DATA) && shift_n[WIDTH-1]);
      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_dsp_zender.sv
// Bench for dsp_zender: frame-level reference model, per-cycle compare, directed and random stimulus.
module tb_dsp_zender;

   localparam int W     = 8;
   localparam int BIT   = 4;
   localparam int TURN  = 2;
   localparam int FRAME = TURN + (W + 2) * BIT;

   logic         clk = 1'b0;
   logic         reset;
   logic         DSPctrl;
   logic [W-1:0] sample_in;
   logic         sample_valid;
   logic         DSPingang;
   logic         busy;
   logic         sample_taken;
   logic         overrun;

   int checks   = 0;
   int failures = 0;

   dsp_zender #(
      .WIDTH       (W),
      .BIT_CYCLES  (BIT),
      .TURN_CYCLES (TURN)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .DSPctrl      (DSPctrl),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .DSPingang    (DSPingang),
      .busy         (busy),
      .sample_taken (sample_taken),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   // Line level expected at a given cycle offset into a frame carrying v.
   function automatic logic line_at(input int off, input logic [W-1:0] v);
      if (off < TURN) return 1'b0;
      if (off < TURN + BIT) return 1'b1;
      if (off < TURN + (W + 1) * BIT) return v[W - 1 - (off - TURN - BIT) / BIT];
      return 1'b0;
   endfunction

   // Reference model: a frame is just a start edge index plus its payload.
   bit           m_valid = 1'b0;
   int           n       = 0;
   int           m_cur   = 0;
   int           last_rst = 0;
   int           m_fs    = -1000;
   logic [W-1:0] m_val   = '0;
   logic [W-1:0] m_shadow = '0;
   bit           m_over  = 1'b0;
   bit [3:0]     hist    = '0;
   bit           sync_a, sync_b, req, was_busy;

   always @(posedge clk) begin
      if (!reset) begin
         m_valid  = 1'b1;
         last_rst = n;
         m_fs     = -1000;
         m_over   = 1'b0;
         m_shadow = '0;
      end else if (m_valid) begin
         // Synchronized level after edge m equals DSPctrl sampled at edge m-1, zero for two edges after reset.
         sync_a   = (n - 1 >= last_rst + 2) ? hist[(n - 2) % 4] : 1'b0;
         sync_b   = (n - 2 >= last_rst + 2) ? hist[(n - 3) % 4] : 1'b0;
         req      = sync_a && !sync_b;
         was_busy = (n - 1 >= m_fs) && (n - 1 < m_fs + FRAME);
         if (req) begin
            if (was_busy) m_over = 1'b1;
            else begin
               m_fs  = n;
               m_val = sample_valid ? sample_in : m_shadow;
            end
         end
         if (sample_valid) m_shadow = sample_in;
      end
      hist[n % 4] = DSPctrl;
      m_cur = n;
      n++;
   end

   always @(negedge clk) begin
      int  off;
      bit  e_busy;
      if (m_valid) begin
         off    = m_cur - m_fs;
         e_busy = (off >= 0) && (off < FRAME);
         chk("busy", 32'(busy), 32'(e_busy));
         chk("line", 32'(DSPingang), 32'(e_busy ? line_at(off, m_val) : 1'b0));
         chk("taken", 32'(sample_taken), 32'(m_cur == m_fs));
         chk("overrun", 32'(overrun), 32'(m_over));
      end
   end

   task automatic run_frame(input logic [W-1:0] v, input bit load, input bit bypass,
                            input int poke_at, output logic [W-1:0] got, output int len);
      logic w[$];
      int   guard;
      if (load && !bypass) begin
         @(negedge clk); sample_in = v; sample_valid = 1'b1;
         @(negedge clk); sample_valid = 1'b0;
      end
      @(negedge clk); DSPctrl = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("pre_busy", 32'(busy), 32'(0));
      if (load && bypass) begin
         sample_in = v; sample_valid = 1'b1;
      end
      @(negedge clk);
      sample_valid = 1'b0;
      chk("taken_k2", 32'(sample_taken), 32'(1));
      chk("busy_k2", 32'(busy), 32'(1));
      guard = 0;
      while (busy && guard < 200) begin
         w.push_back(DSPingang);
         if (w.size() == 3) DSPctrl = 1'b0;
         if (w.size() == poke_at) DSPctrl = 1'b1;
         if (w.size() == poke_at + 4) DSPctrl = 1'b0;
         @(negedge clk);
         guard++;
      end
      chk("busy_end", 32'(busy), 32'(0));
      len = w.size();
      got = 'x;
      if (len == FRAME) begin
         for (int i = 0; i < W; i++) got[W - 1 - i] = w[TURN + BIT + i * BIT + BIT / 2];
         chk("start_bit", 32'(w[TURN]), 32'(1));
         chk("turn_low", 32'(w[0]), 32'(0));
         chk("stop_low", 32'(w[FRAME - 1]), 32'(0));
      end
   endtask

   initial begin
      logic [W-1:0] got;
      int           len;

      reset = 1'b0; DSPctrl = 1'b0; sample_in = '0; sample_valid = 1'b0;

      // Reset held while the request line toggles.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         DSPctrl = ~DSPctrl;
         chk("rst_busy", 32'(busy), 32'(0));
         chk("rst_line", 32'(DSPingang), 32'(0));
         chk("rst_over", 32'(overrun), 32'(0));
      end
      @(negedge clk); DSPctrl = 1'b0; reset = 1'b1;
      repeat (10) @(negedge clk);
      chk("no_frame", 32'(busy), 32'(0));

      run_frame(8'hA5, 1'b1, 1'b0, -1, got, len);
      chk("frame_a5", 32'(got), 32'(8'hA5));
      chk("len_a5", 32'(len), 32'(42));

      run_frame(8'h00, 1'b0, 1'b0, -1, got, len);
      chk("resend_a5", 32'(got), 32'(8'hA5));

      run_frame(8'h3C, 1'b1, 1'b1, -1, got, len);
      chk("bypass_3c", 32'(got), 32'(8'h3C));
      run_frame(8'h00, 1'b0, 1'b0, -1, got, len);
      chk("shadow_3c", 32'(got), 32'(8'h3C));

      chk("over_clear", 32'(overrun), 32'(0));
      run_frame(8'h5A, 1'b1, 1'b0, 16, got, len);
      chk("frame_5a_poked", 32'(got), 32'(8'h5A));
      chk("over_set", 32'(overrun), 32'(1));
      run_frame(8'h00, 1'b0, 1'b0, -1, got, len);
      chk("after_over", 32'(got), 32'(8'h5A));
      chk("over_sticky", 32'(overrun), 32'(1));

      // Reset in the middle of data bit 3 aborts the frame and clears the shadow.
      @(negedge clk); DSPctrl = 1'b1;
      repeat (3) @(negedge clk);
      DSPctrl = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_line", 32'(DSPingang), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      reset = 1'b1;
      repeat (4) @(negedge clk);
      run_frame(8'h00, 1'b0, 1'b0, -1, got, len);
      chk("after_rst_zero", 32'(got), 32'(8'h00));

      // Random traffic, checked every cycle against the model.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 19) == 0) DSPctrl = ~DSPctrl;
         sample_valid = ($urandom_range(0, 5) == 0);
         sample_in    = W'($urandom);
         reset        = ($urandom_range(0, 699) != 0);
      end
      @(negedge clk);
      sample_valid = 1'b0; reset = 1'b1; DSPctrl = 1'b0;
      repeat (60) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
